// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the ADC scan scheduler: FSM encodings,
// result entry layout and UART hi-byte field positions.
package adc_sched_pkg;

   localparam int CH_W      = 3;
   localparam int CODE_W    = 10;
   localparam int N_CH      = 1 << CH_W;
   localparam int ENTRY_W   = CH_W + CODE_W;
   localparam int HI_CODE_W = CODE_W - 8;

   // Hi byte carries {ch, 3'b000, code[9:8]}.
   localparam int HI_CH_LSB   = 5;
   localparam int HI_CODE_LSB = 0;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_NEXT} scan_state_t;
   typedef enum logic [2:0] {T_IDLE, T_LO, T_LO_W, T_HI, T_HI_W} tx_state_t;

   typedef struct packed {
      logic [CH_W-1:0]   ch;
      logic [CODE_W-1:0] code;
   } entry_t;

   // Lowest set channel at or above 'from'; MSB of the result flags "found".
   function automatic logic [CH_W:0] first_ch_from(input logic [N_CH-1:0] mask,
                                                   input logic [CH_W:0]   from);
      logic [CH_W:0] r;
      r = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (mask[i] && ((CH_W + 1)'(i) >= from)) r = {1'b1, CH_W'(i)};
      end
      return r;
   endfunction

   function automatic logic [7:0] lo_byte(input entry_t e);
      return e.code[7:0];
   endfunction

   function automatic logic [7:0] hi_byte(input entry_t e);
      logic [7:0] b;
      b = '0;
      b[HI_CH_LSB +: CH_W]        = e.ch;
      b[HI_CODE_LSB +: HI_CODE_W] = e.code[CODE_W-1 -: HI_CODE_W];
      return b;
   endfunction

endpackage

// File: rtl/adc_scan_scheduler_if.sv
// Scheduler-facing handshakes: conversion request to the SPI ADC engine and
// byte launch to the UART transmitter.
interface adc_scan_scheduler_if;

   // conv_req is a level held until the single-cycle conv_done (data valid that
   // cycle); tx_start is a single-cycle launch and tx_data holds until tx_busy falls.
   logic                             conv_req;
   logic [adc_sched_pkg::CH_W-1:0]   conv_ch;
   logic                             conv_done;
   logic [adc_sched_pkg::CODE_W-1:0] conv_data;
   logic                             tx_start;
   logic [7:0]                       tx_data;
   logic                             tx_busy;

   modport master (
      output conv_req, conv_ch, tx_start, tx_data,
      input  conv_done, conv_data, tx_busy
   );

   modport slave (
      input  conv_req, conv_ch, tx_start, tx_data,
      output conv_done, conv_data, tx_busy
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data; a push into a
// full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 13,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (level == (AW + 1)'(DEPTH));
   assign empty    = (level == '0);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         level <= level + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
      end
   end

endmodule

// File: rtl/adc_scan_scheduler.sv
// Periodic round-robin scan of the enabled ADC channels; each {ch, code}
// result is buffered and sent to the UART as a lo byte then a hi byte.
module adc_scan_scheduler
   import adc_sched_pkg::*;
#(
   parameter int CLK_HZ     = 25_000_000,
   parameter int SAMPLE_DIV = CLK_HZ / 50_000,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        run,
   input  logic [N_CH-1:0]             ch_enable,
   adc_scan_scheduler_if.master        bus,
   output logic                        scan_active,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        overflow,
   output logic                        overrun,
   output scan_state_t                 dbg_scan_state,
   output tx_state_t                   dbg_tx_state
);

   localparam int CNT_W = $clog2(SAMPLE_DIV);

   logic [CNT_W-1:0] period_cnt;
   logic             trigger;
   scan_state_t      scan_state;
   logic [N_CH-1:0]  mask_q;
   logic [CH_W-1:0]  ch_q;
   logic [CH_W:0]    first_ch;
   logic [CH_W:0]    next_ch;
   logic             push;
   entry_t           push_entry;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [ENTRY_W-1:0] fifo_dout;
   tx_state_t        tx_state;
   entry_t           hold_q;
   logic             busy_seen;

   assign trigger    = (period_cnt == CNT_W'(SAMPLE_DIV - 1));
   assign first_ch   = first_ch_from(ch_enable, '0);
   assign next_ch    = first_ch_from(mask_q, {1'b0, ch_q} + (CH_W + 1)'(1));
   assign push       = bus.conv_req && bus.conv_done;
   assign push_entry = '{ch: ch_q, code: bus.conv_data};
   assign fifo_pop   = (tx_state == T_IDLE) && !fifo_empty && !bus.tx_busy;

   assign dbg_scan_state = scan_state;
   assign dbg_tx_state   = tx_state;

   always_ff @(posedge clk) begin
      if (rst || trigger) period_cnt <= '0;
      else                period_cnt <= period_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_state   <= S_IDLE;
         mask_q       <= '0;
         ch_q         <= '0;
         bus.conv_req <= 1'b0;
         bus.conv_ch  <= '0;
         scan_active  <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         if (trigger && scan_active) overrun <= 1'b1;
         case (scan_state)
            S_IDLE: begin
               if (trigger && run && first_ch[CH_W]) begin
                  mask_q      <= ch_enable;
                  ch_q        <= first_ch[CH_W-1:0];
                  scan_active <= 1'b1;
                  scan_state  <= S_REQ;
               end
            end
            // S_NEXT raises conv_req early, so a done may already land in S_REQ.
            S_REQ, S_WAIT: begin
               if (push) begin
                  bus.conv_req <= 1'b0;
                  scan_state   <= S_NEXT;
               end else begin
                  bus.conv_req <= 1'b1;
                  bus.conv_ch  <= ch_q;
                  scan_state   <= S_WAIT;
               end
            end
            S_NEXT: begin
               if (run && next_ch[CH_W]) begin
                  ch_q         <= next_ch[CH_W-1:0];
                  bus.conv_req <= 1'b1;
                  bus.conv_ch  <= next_ch[CH_W-1:0];
                  scan_state   <= S_REQ;
               end else begin
                  scan_active <= 1'b0;
                  scan_state  <= S_IDLE;
               end
            end
            default: scan_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                               overflow <= 1'b0;
      else if (push && fifo_full && !fifo_pop) overflow <= 1'b1;
   end

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .pop_data  (fifo_dout),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state     <= T_IDLE;
         hold_q       <= '0;
         busy_seen    <= 1'b0;
         bus.tx_start <= 1'b0;
         bus.tx_data  <= '0;
      end else begin
         bus.tx_start <= 1'b0;
         case (tx_state)
            T_IDLE: begin
               if (fifo_pop) begin
                  hold_q   <= fifo_dout;
                  tx_state <= T_LO;
               end
            end
            T_LO: begin
               bus.tx_start <= 1'b1;
               bus.tx_data  <= lo_byte(hold_q);
               busy_seen    <= 1'b0;
               tx_state     <= T_LO_W;
            end
            T_HI: begin
               bus.tx_start <= 1'b1;
               bus.tx_data  <= hi_byte(hold_q);
               busy_seen    <= 1'b0;
               tx_state     <= T_HI_W;
            end
            // A byte is complete only after tx_busy has been seen high, then low.
            T_LO_W, T_HI_W: begin
               if (!busy_seen)        busy_seen <= bus.tx_busy;
               else if (!bus.tx_busy) tx_state  <= (tx_state == T_LO_W) ? T_HI : T_IDLE;
            end
            default: tx_state <= T_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler with an SPI ADC stub and a UART stub.
module tb_adc_scan_scheduler;
   import adc_sched_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic [7:0]  ch_enable = '0;
   logic        scan_active;
   logic [4:0]  fifo_level;
   logic        overflow;
   logic        overrun;
   scan_state_t dbg_scan_state;
   tx_state_t   dbg_tx_state;

   int adc_delay  = 3;
   int adc_mode   = 0;
   int uart_len   = 5;
   bit force_busy = 1'b0;
   int conv_count = 0;
   int cyc        = 0;
   int n_vec      = 0;
   int n_err      = 0;

   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   logic [2:0] req_q[$];

   adc_scan_scheduler_if bus();

   adc_scan_scheduler #(
      .CLK_HZ     (25_000_000),
      .SAMPLE_DIV (50),
      .FIFO_DEPTH (16)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .run            (run),
      .ch_enable      (ch_enable),
      .bus            (bus),
      .scan_active    (scan_active),
      .fifo_level     (fifo_level),
      .overflow       (overflow),
      .overrun        (overrun),
      .dbg_scan_state (dbg_scan_state),
      .dbg_tx_state   (dbg_tx_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stubs ----------------
   function automatic logic [9:0] adc_code(input logic [2:0] ch);
      case (adc_mode)
         0:       return 10'h2A5;
         1:       return 10'(32'(ch) * 100);
         default: return 10'(conv_count);
      endcase
   endfunction

   initial begin
      bit pending;
      int cnt;
      pending = 1'b0;
      cnt = 0;
      bus.conv_done = 1'b0;
      bus.conv_data = '0;
      forever begin
         @(negedge clk);
         bus.conv_done = 1'b0;
         if (rst) pending = 1'b0;
         else begin
            if (bus.conv_req === 1'b1 && !pending) begin
               pending = 1'b1;
               cnt = adc_delay;
               req_q.push_back(bus.conv_ch);
            end
            if (pending) begin
               if (cnt == 0) begin
                  bus.conv_done = 1'b1;
                  bus.conv_data = adc_code(bus.conv_ch);
                  conv_count++;
                  pending = 1'b0;
               end else cnt--;
            end
         end
      end
   end

   initial begin
      int busy_cnt;
      busy_cnt = 0;
      bus.tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.tx_start === 1'b1) begin
            got_q.push_back(bus.tx_data);
            busy_cnt = uart_len;
         end else if (busy_cnt > 0) busy_cnt--;
         bus.tx_busy = force_busy || (busy_cnt > 0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset(input logic [7:0] en, input int mode, input int dly,
                           input int ulen, input bit fb);
      rst = 1'b1;
      run = 1'b0;
      adc_mode = mode;
      adc_delay = dly;
      uart_len = ulen;
      force_busy = fb;
      repeat (3) tick();
      got_q.delete();
      exp_q.delete();
      req_q.delete();
      conv_count = 0;
      ch_enable = en;
      run = 1'b1;
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic wait_bytes(input int n, input int limit);
      int k;
      k = 0;
      while (got_q.size() < n && k < limit) begin
         tick();
         k++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (4) tick();
      n_vec++; if (bus.conv_req !== 1'b0) begin n_err++; $display("FAIL rst_conv_req: got %b want 0", bus.conv_req); end
      n_vec++; if (bus.conv_ch !== 3'd0) begin n_err++; $display("FAIL rst_conv_ch: got %0d want 0", bus.conv_ch); end
      n_vec++; if (bus.tx_start !== 1'b0) begin n_err++; $display("FAIL rst_tx_start: got %b want 0", bus.tx_start); end
      n_vec++; if (bus.tx_data !== 8'h00) begin n_err++; $display("FAIL rst_tx_data: got %h want 00", bus.tx_data); end
      n_vec++; if (scan_active !== 1'b0) begin n_err++; $display("FAIL rst_scan_active: got %b want 0", scan_active); end
      n_vec++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL rst_fifo_level: got %0d want 0", fifo_level); end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b want 0", overflow); end
      n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rst_overrun: got %b want 0", overrun); end
      n_vec++; if (dbg_scan_state !== S_IDLE) begin n_err++; $display("FAIL rst_scan_state: got %0d want %0d", dbg_scan_state, S_IDLE); end
      n_vec++; if (dbg_tx_state !== T_IDLE) begin n_err++; $display("FAIL rst_tx_state: got %0d want %0d", dbg_tx_state, T_IDLE); end
   endtask

   task automatic test_single_channel();
      int k;
      logic [7:0] got;
      do_reset(8'h01, 0, 3, 5, 1'b0);
      k = 0;
      while (bus.conv_req !== 1'b1 && k < 200) begin tick(); k++; end
      n_vec++; if (cyc != 51) begin n_err++; $display("FAIL single_first_req_cycle: got %0d want 51", cyc); end
      n_vec++; if (bus.conv_ch !== 3'd0) begin n_err++; $display("FAIL single_conv_ch: got %0d want 0", bus.conv_ch); end
      k = 0;
      while (bus.conv_done !== 1'b1 && k < 50) begin tick(); k++; end
      tick();
      n_vec++; if (fifo_level !== 5'd1) begin n_err++; $display("FAIL single_level_after_done: got %0d want 1", fifo_level); end
      tick();
      n_vec++; if (bus.tx_start !== 1'b0) begin n_err++; $display("FAIL single_tx_start_early: got %b want 0", bus.tx_start); end
      tick();
      n_vec++; if (bus.tx_start !== 1'b1) begin n_err++; $display("FAIL single_tx_start: got %b want 1", bus.tx_start); end
      n_vec++; if (bus.tx_data !== 8'hA5) begin n_err++; $display("FAIL single_tx_data_lo: got %h want a5", bus.tx_data); end
      k = 0;
      while (bus.conv_req === 1'b1 && k < 100) begin tick(); k++; end
      while (bus.conv_req !== 1'b1 && k < 200) begin tick(); k++; end
      n_vec++; if (cyc != 101) begin n_err++; $display("FAIL single_second_req_cycle: got %0d want 101", cyc); end
      wait_bytes(4, 200);
      exp_q = '{8'hA5, 8'h02, 8'hA5, 8'h02};
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < got_q.size()) ? got_q[i] : 8'hxx;
         n_vec++; if (got !== exp_q[i]) begin n_err++; $display("FAIL single_byte%0d: got %h want %h", i, got, exp_q[i]); end
      end
   endtask

   task automatic test_sparse_mask();
      logic [7:0] got;
      logic [2:0] exp_ch[3];
      logic [2:0] got_ch;
      do_reset(8'b1010_0100, 1, 3, 5, 1'b0);
      wait_bytes(6, 400);
      exp_ch = '{3'd2, 3'd5, 3'd7};
      for (int i = 0; i < 3; i++) begin
         got_ch = (i < req_q.size()) ? req_q[i] : 3'bxxx;
         n_vec++; if (got_ch !== exp_ch[i]) begin n_err++; $display("FAIL sparse_req%0d: got %0d want %0d", i, got_ch, exp_ch[i]); end
      end
      exp_q = '{8'hC8, 8'h40, 8'hF4, 8'hA1, 8'hBC, 8'hE2};
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < got_q.size()) ? got_q[i] : 8'hxx;
         n_vec++; if (got !== exp_q[i]) begin n_err++; $display("FAIL sparse_byte%0d: got %h want %h", i, got, exp_q[i]); end
      end
   endtask

   task automatic test_overrun();
      int k;
      logic [2:0] got_ch;
      do_reset(8'hFF, 0, 60, 5, 1'b0);
      k = 0;
      while (bus.conv_req !== 1'b1 && k < 200) begin tick(); k++; end
      n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL overrun_early: got %b want 0", overrun); end
      n_vec++; if (scan_active !== 1'b1) begin n_err++; $display("FAIL overrun_scan_active: got %b want 1", scan_active); end
      k = 0;
      while (overrun !== 1'b1 && k < 100) begin tick(); k++; end
      n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_set: got %b want 1", overrun); end
      k = 0;
      while (scan_active === 1'b1 && k < 800) begin tick(); k++; end
      n_vec++; if (req_q.size() != 8) begin n_err++; $display("FAIL overrun_req_count: got %0d want 8", req_q.size()); end
      for (int i = 0; i < 8; i++) begin
         got_ch = (i < req_q.size()) ? req_q[i] : 3'bxxx;
         n_vec++; if (got_ch !== 3'(i)) begin n_err++; $display("FAIL overrun_req%0d: got %0d want %0d", i, got_ch, i); end
      end
      n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
   endtask

   task automatic test_overflow();
      int k;
      logic [7:0] got;
      do_reset(8'hFF, 2, 1, 5, 1'b1);
      k = 0;
      while (conv_count < 24 && k < 400) begin tick(); k++; end
      repeat (4) tick();
      run = 1'b0;
      n_vec++; if (fifo_level !== 5'd16) begin n_err++; $display("FAIL overflow_level: got %0d want 16", fifo_level); end
      n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL overflow_flag: got %b want 1", overflow); end
      n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL overflow_no_overrun: got %b want 0", overrun); end
      force_busy = 1'b0;
      wait_bytes(32, 800);
      repeat (40) tick();
      n_vec++; if (got_q.size() != 32) begin n_err++; $display("FAIL overflow_byte_count: got %0d want 32", got_q.size()); end
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back(8'(i));
         exp_q.push_back(8'((i % 8) << 5));
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < got_q.size()) ? got_q[i] : 8'hxx;
         n_vec++; if (got !== exp_q[i]) begin n_err++; $display("FAIL overflow_byte%0d: got %h want %h", i, got, exp_q[i]); end
      end
      n_vec++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL overflow_drained: got %0d want 0", fifo_level); end
   endtask

   task automatic test_run_drop();
      int k;
      logic [7:0] got;
      do_reset(8'hFF, 1, 3, 5, 1'b0);
      k = 0;
      while (!(bus.conv_req === 1'b1 && bus.conv_ch === 3'd3) && k < 200) begin tick(); k++; end
      run = 1'b0;
      k = 0;
      while (bus.conv_done !== 1'b1 && k < 50) begin tick(); k++; end
      tick();
      n_vec++; if (scan_active !== 1'b1) begin n_err++; $display("FAIL rundrop_active_d1: got %b want 1", scan_active); end
      tick();
      n_vec++; if (scan_active !== 1'b0) begin n_err++; $display("FAIL rundrop_active_d2: got %b want 0", scan_active); end
      wait_bytes(8, 300);
      repeat (60) tick();
      n_vec++; if (req_q.size() != 4) begin n_err++; $display("FAIL rundrop_req_count: got %0d want 4", req_q.size()); end
      n_vec++; if (got_q.size() != 8) begin n_err++; $display("FAIL rundrop_byte_count: got %0d want 8", got_q.size()); end
      exp_q = '{8'h00, 8'h00, 8'h64, 8'h20, 8'hC8, 8'h40, 8'h2C, 8'h61};
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < got_q.size()) ? got_q[i] : 8'hxx;
         n_vec++; if (got !== exp_q[i]) begin n_err++; $display("FAIL rundrop_byte%0d: got %h want %h", i, got, exp_q[i]); end
      end
   endtask

   task automatic test_reset_mid_op();
      int k;
      logic [7:0] got;
      // Reset while the scan FSM waits on a slow conversion.
      do_reset(8'h01, 0, 60, 5, 1'b0);
      k = 0;
      while (bus.conv_req !== 1'b1 && k < 200) begin tick(); k++; end
      repeat (3) tick();
      n_vec++; if (dbg_scan_state !== S_WAIT) begin n_err++; $display("FAIL midrst_in_wait: got %0d want %0d", dbg_scan_state, S_WAIT); end
      rst = 1'b1;
      tick();
      n_vec++; if (bus.conv_req !== 1'b0) begin n_err++; $display("FAIL midrst_conv_req: got %b want 0", bus.conv_req); end
      n_vec++; if (scan_active !== 1'b0) begin n_err++; $display("FAIL midrst_scan_active: got %b want 0", scan_active); end
      n_vec++; if (dbg_scan_state !== S_IDLE) begin n_err++; $display("FAIL midrst_scan_state: got %0d want %0d", dbg_scan_state, S_IDLE); end
      adc_delay = 3;
      rst = 1'b0;
      cyc = 0;
      k = 0;
      while (bus.conv_req !== 1'b1 && k < 200) begin tick(); k++; end
      n_vec++; if (cyc != 51) begin n_err++; $display("FAIL midrst_resume_req_cycle: got %0d want 51", cyc); end

      // Reset while the tx FSM waits out the lo byte.
      do_reset(8'h01, 0, 3, 30, 1'b0);
      wait_bytes(1, 200);
      n_vec++; if (dbg_tx_state !== T_LO_W) begin n_err++; $display("FAIL midrst_in_lo_w: got %0d want %0d", dbg_tx_state, T_LO_W); end
      rst = 1'b1;
      tick();
      n_vec++; if (bus.tx_start !== 1'b0) begin n_err++; $display("FAIL midrst_tx_start: got %b want 0", bus.tx_start); end
      n_vec++; if (bus.tx_data !== 8'h00) begin n_err++; $display("FAIL midrst_tx_data: got %h want 00", bus.tx_data); end
      n_vec++; if (dbg_tx_state !== T_IDLE) begin n_err++; $display("FAIL midrst_tx_state: got %0d want %0d", dbg_tx_state, T_IDLE); end
      n_vec++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL midrst_fifo_level: got %0d want 0", fifo_level); end
      rst = 1'b0;
      cyc = 0;
      got_q.delete();
      wait_bytes(2, 300);
      exp_q = '{8'hA5, 8'h02};
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < got_q.size()) ? got_q[i] : 8'hxx;
         n_vec++; if (got !== exp_q[i]) begin n_err++; $display("FAIL midrst_resume_byte%0d: got %h want %h", i, got, exp_q[i]); end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single_channel();
      test_sparse_mask();
      test_overrun();
      test_overflow();
      test_run_drop();
      test_reset_mid_op();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/adc_scan_scheduler.md
# adc_scan_scheduler

Sequences round-robin conversions of the 8-channel, 10-bit SPI ADC and streams the results to the UART byte transmitter. It replaces the free-running, hard-coded single-channel timing with an explicit scheduler. Each scan period it requests one conversion per enabled channel from the SPI ADC engine and buffers each {channel, code} result in a FIFO. It then frames each result as two UART bytes. It sits between the SPI ADC engine (conversion request/done handshake) and the UART transmitter (start/busy handshake).

## Interface
- CLK_HZ, 25000000, system clock frequency; informational, used only for the SAMPLE_DIV default.
- SAMPLE_DIV, 500, clocks per scan trigger (500 = 20 us at 25 MHz); must be ≥ 2.
- FIFO_DEPTH, 16, result FIFO entries; power of two.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; enables scan triggers.
- ch_enable  in  8  per-channel enable mask; sampled at scan start.
- conv_req  out  1  level; held high until conv_done.
- conv_ch  out  3  channel for the current request; stable while conv_req=1.
- conv_done  in  1  one-cycle pulse from the SPI engine; conv_data is valid in the same cycle.
- conv_data  in  10  ADC code.
- tx_start  out  1  one-cycle pulse; launches one UART byte.
- tx_data  out  8  byte to send; stable from tx_start until tx_busy falls.
- tx_busy  in  1  UART busy.
- scan_active  out  1  high while a scan is in progress.
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; a result was dropped because the FIFO was full.
- overrun  out  1  sticky; a trigger arrived while a scan was still active.

## Operation
- Period counter runs from 0 to SAMPLE_DIV-1 and wraps. The trigger is the cycle in which the count equals SAMPLE_DIV-1. The counter runs regardless of run.
- Scan FSM states: S_IDLE, S_REQ, S_WAIT, S_NEXT.
  - S_IDLE → S_REQ on trigger when run=1 and ch_enable≠0. On that transition, latch the mask, set ch to the lowest enabled channel, and assert scan_active.
  - S_REQ: drive conv_req=1 and conv_ch=ch; go to S_WAIT.
  - S_WAIT: hold conv_req. On conv_done, drop conv_req, push {ch, conv_data}, and go to S_NEXT.
  - S_NEXT: if a higher enabled channel exists in the latched mask, set ch to it and go to S_REQ; otherwise go to S_IDLE and deassert scan_active.
- Trigger while scan_active=1: ignored; set overrun.
- run falling mid-scan: the outstanding conversion completes and its result is stored. S_NEXT then returns to S_IDLE and no further channels are requested.
- Push when the FIFO is full: the result is dropped and overflow is set. With a simultaneous pop, the push succeeds.
- Tx FSM states: T_IDLE, T_LO, T_LO_W, T_HI, T_HI_W.
  - T_IDLE: if the FIFO is non-empty and tx_busy=0, pop the entry into a holding register and go to T_LO.
  - T_LO: pulse tx_start with tx_data=code[7:0]; go to T_LO_W.
  - T_LO_W: wait for tx_busy=1, then for tx_busy=0; go to T_HI.
  - T_HI: pulse tx_start with tx_data={ch[2:0], 3'b000, code[9:8]}; go to T_HI_W.
  - T_HI_W: same wait as T_LO_W; then go to T_IDLE.
- overflow and overrun are cleared only by rst.

## Timing
- Reset values: conv_req=0, conv_ch=0, tx_start=0, tx_data=0, scan_active=0, fifo_level=0, overflow=0, overrun=0. All FSMs reset to their idle state, the counter to 0, and the FIFO to empty.
- rst mid-operation: conv_req drops the next cycle, and any in-flight UART frame is abandoned (the UART finishes it on its own). The FIFO contents are lost.
- Trigger cycle to conv_req=1: 2 cycles (S_IDLE→S_REQ, then registered output).
- conv_done to fifo_level increment: 1 cycle.
- conv_done to next conv_req: 2 cycles.
- FIFO non-empty with tx_busy=0 to tx_start: 2 cycles.
- tx_busy must rise within 4 cycles of tx_start. If it does not, the FSM remains waiting; there is no timeout.
- Channels within a scan are requested in ascending order only. No pipelining: at most one outstanding conversion.

## Structure
- Shared package adc_sched_pkg contains:
  - scan and tx state enums;
  - CH_W=3, CODE_W=10;
  - entry layout {ch, code} (13 bits);
  - hi-byte field positions.
- Sub-module sync_fifo: width 13, depth FIFO_DEPTH, push/pop/full/empty/level, same-cycle push+pop when full allowed. The scheduler instantiates it once.

## Test plan
- Single channel: SAMPLE_DIV=50, ch_enable=8'h01, stub returns 10'h2A5 → conv_ch=0; UART bytes 8'hA5 then 8'h02, repeating every 50 cycles.
- Sparse mask: ch_enable=8'b1010_0100, stub code = ch×100 → requests in order ch 2, 5, 7; bytes 0xC8,0x40; 0xF4,0xA1; 0xBC,0xE2.
- Overrun: stub delays conv_done 60 cycles with SAMPLE_DIV=50 and all channels enabled → overrun=1; no second scan starts until scan_active falls.
- Overflow: tx_busy forced high, FIFO_DEPTH=16, all 8 channels, 3 scans → fifo_level saturates at 16, overflow=1, and the first 16 entries are preserved in order after tx_busy releases.
- run dropped during the ch 3 request → ch 3 result stored, no ch 4 request, scan_active falls 2 cycles after conv_done.
- rst asserted in S_WAIT and T_LO_W → next cycle all outputs at reset values; operation resumes cleanly on the next trigger.
